// File: rtl/capi_jctrl_mc.sv
// capi_jctrl_mc: multi-channel CAPI job control with timed AFU reset, per-channel completion and command drain.
module capi_jctrl_mc #(
  parameter int channels     = 4,
  parameter int afuerr_width = 8,
  parameter int reset_hold   = 16,
  parameter int outst_width  = 8,
  parameter int ctxtid_width = 10
) (
  input  logic                             clk,
  input  logic                             i_reset,
  input  logic                             i_fatal_error,
  input  logic                             ha_jval,
  input  logic [7:0]                       ha_jcom,
  input  logic [63:0]                      ha_jea,
  input  logic                             ha_jeapar,
  output logic                             ah_jrunning,
  output logic                             ah_jdone,
  output logic [63:0]                      ah_jerror,
  output logic                             ah_jcack,
  output logic                             ah_tbreq,
  output logic                             ah_jyield,
  input  logic [channels-1:0]              i_app_done,
  input  logic [channels*afuerr_width-1:0] i_app_error,
  input  logic                             i_cmd_sent,
  input  logic                             i_rsp_rcvd,
  output logic                             o_cmd_en,
  output logic                             o_ll_v,
  output logic [15:0]                      o_ll_cmd,
  output logic [ctxtid_width-1:0]          o_ll_ctxt,
  input  logic                             i_ll_ack,
  output logic                             o_reset,
  output logic                             o_s1_perror,
  output logic                             o_perror,
  output logic                             o_ll_drop,
  output logic                             o_outst_err
);
  localparam int hw = $clog2(reset_hold + 1);
  typedef enum logic [2:0] {IDLE, RUNNING, DRAIN, DONE, RESET} state_t;
  state_t state, state_nxt;
  logic [hw-1:0] hold;
  logic [channels-1:0] mask, mask_nxt;
  logic err_v, pick_v;
  logic [3:0] err_idx, pick_idx;
  logic [afuerr_width-1:0] err_code, pick_code;
  logic [outst_width-1:0] outst;
  logic jrun, ll_pend, rst_p1, rst_p2;
  logic cmd_reset, cmd_start, cmd_ll, ll_accept, ll_reject;
  always_comb begin
    cmd_reset = ha_jval && ha_jcom == 8'h80;
    cmd_start = ha_jval && ha_jcom == 8'h90;
    cmd_ll    = ha_jval && ha_jcom == 8'h45;
    ll_accept = cmd_ll && state != RESET && !ll_pend;
    ll_reject = cmd_ll && state != RESET && ll_pend;
    mask_nxt  = mask | i_app_done;
    state_nxt = cmd_reset ? RESET :
                (state == IDLE && cmd_start) ? RUNNING :
                (state == RUNNING && &mask_nxt) ? DRAIN :
                (state == DRAIN && outst == '0 && !i_cmd_sent) ? DONE :
                (state == DONE) ? IDLE :
                (state == RESET && hold == hw'(1)) ? DONE : state;
  end
  // Descending scan so the lowest newly-done channel with a nonzero code wins.
  always_comb begin
    pick_v    = 1'b0;
    pick_idx  = '0;
    pick_code = '0;
    for (int i = channels - 1; i >= 0; i--)
      if (i_app_done[i] && !mask[i] && |i_app_error[i*afuerr_width +: afuerr_width]) begin
        pick_v    = 1'b1;
        pick_idx  = 4'(i);
        pick_code = i_app_error[i*afuerr_width +: afuerr_width];
      end
  end
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state       <= IDLE;
      hold        <= '0;
      mask        <= '0;
      err_v       <= 1'b0;
      err_idx     <= '0;
      err_code    <= '0;
      outst       <= '0;
      jrun        <= 1'b0;
      o_cmd_en    <= 1'b0;
      ll_pend     <= 1'b0;
      o_ll_v      <= 1'b0;
      o_ll_cmd    <= '0;
      o_ll_ctxt   <= '0;
      ah_jcack    <= 1'b0;
      o_s1_perror <= 1'b0;
      o_perror    <= 1'b0;
      o_ll_drop   <= 1'b0;
      o_outst_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold     <= cmd_reset ? hw'(reset_hold) : (hold != '0 ? hold - hw'(1) : '0);
      jrun     <= state == RUNNING || state == DRAIN;
      o_cmd_en <= state == RUNNING;
      if (cmd_reset || state == DONE) begin
        mask  <= '0;
        err_v <= 1'b0;
      end else if (state == RUNNING) begin
        mask <= mask_nxt;
        if (!err_v && pick_v) begin
          err_v    <= 1'b1;
          err_idx  <= pick_idx;
          err_code <= pick_code;
        end
      end
      if (cmd_reset || state == RESET)
        outst <= '0;
      else if (i_cmd_sent && !i_rsp_rcvd && outst != '1)
        outst <= outst + 1'b1;
      else if (!i_cmd_sent && i_rsp_rcvd && outst != '0)
        outst <= outst - 1'b1;
      o_outst_err <= o_outst_err | (i_rsp_rcvd && !i_cmd_sent && outst == '0 && state != RESET);
      o_ll_v   <= ll_accept;
      ah_jcack <= i_ll_ack && ll_pend;
      if (cmd_reset)
        ll_pend <= 1'b0;
      else if (ll_accept)
        ll_pend <= 1'b1;
      else if (i_ll_ack)
        ll_pend <= 1'b0;
      if (ll_accept) begin
        o_ll_cmd  <= ha_jea[63:48];
        o_ll_ctxt <= {ha_jea[ctxtid_width-2:0], ~^ha_jea[ctxtid_width-2:0]};
      end
      o_ll_drop   <= o_ll_drop | ll_reject;
      o_s1_perror <= o_s1_perror | (ha_jval && ~^{ha_jea, ha_jeapar});
      o_perror    <= o_s1_perror;
    end
  end
  // Two-stage pipeline driven by i_reset as well, so it needs no reset branch.
  always_ff @(posedge clk) begin
    rst_p1 <= (state == RESET || i_reset) && !i_fatal_error;
    rst_p2 <= rst_p1;
  end
  assign o_reset     = rst_p2;
  assign ah_jrunning = jrun && (state == RUNNING || state == DRAIN);
  assign ah_jdone    = state == DONE;
  assign ah_jerror   = (state == DONE && err_v) ?
                       ((64'd1 << 63) | (64'(err_idx) << afuerr_width) | 64'(err_code)) : 64'd0;
  assign ah_tbreq    = 1'b0;
  assign ah_jyield   = 1'b0;
endmodule

// File: tb/tb_capi_jctrl_mc.sv
// tb_capi_jctrl_mc: directed stimulus checked against a cycle model of the job-control rules.
module tb_capi_jctrl_mc;
  localparam int CH = 4, AW = 8, RH = 16, OMAX = 255;
  localparam int P_IDLE = 0, P_RUN = 1, P_DRAIN = 2, P_DONE = 3, P_RST = 4;
  logic clk = 0, i_reset = 1, i_fatal_error = 0, ha_jval = 0, ha_jeapar = 0;
  logic [7:0] ha_jcom = 0;
  logic [63:0] ha_jea = 0;
  logic [CH-1:0] i_app_done = 0;
  logic [CH*AW-1:0] i_app_error = 0;
  logic i_cmd_sent = 0, i_rsp_rcvd = 0, i_ll_ack = 0;
  logic ah_jrunning, ah_jdone, ah_jcack, ah_tbreq, ah_jyield, o_cmd_en, o_ll_v, o_reset;
  logic o_s1_perror, o_perror, o_ll_drop, o_outst_err;
  logic [63:0] ah_jerror;
  logic [15:0] o_ll_cmd;
  logic [9:0] o_ll_ctxt;
  int total = 0, bad = 0;
  bit chk_en = 0;

  capi_jctrl_mc dut (
    .clk(clk), .i_reset(i_reset), .i_fatal_error(i_fatal_error), .ha_jval(ha_jval),
    .ha_jcom(ha_jcom), .ha_jea(ha_jea), .ha_jeapar(ha_jeapar), .ah_jrunning(ah_jrunning),
    .ah_jdone(ah_jdone), .ah_jerror(ah_jerror), .ah_jcack(ah_jcack), .ah_tbreq(ah_tbreq),
    .ah_jyield(ah_jyield), .i_app_done(i_app_done), .i_app_error(i_app_error),
    .i_cmd_sent(i_cmd_sent), .i_rsp_rcvd(i_rsp_rcvd), .o_cmd_en(o_cmd_en), .o_ll_v(o_ll_v),
    .o_ll_cmd(o_ll_cmd), .o_ll_ctxt(o_ll_ctxt), .i_ll_ack(i_ll_ack), .o_reset(o_reset),
    .o_s1_perror(o_s1_perror), .o_perror(o_perror), .o_ll_drop(o_ll_drop), .o_outst_err(o_outst_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: job phase, hold countdown, done set, first error, outstanding count, flags.
  int m_ph = P_IDLE, m_prev = P_IDLE, m_hold = 0, m_out = 0;
  logic [CH-1:0] m_mask = 0;
  logic [63:0] m_err = 0;
  bit m_r1 = 0, m_r2 = 0, m_llpend = 0, m_llv = 0, m_jcack = 0;
  bit m_s1 = 0, m_perr = 0, m_drop = 0, m_oerr = 0;
  logic [15:0] m_llcmd = 0;
  int m_llctxt = 0;

  always @(posedge clk) begin
    int old, nph, d;
    bit rc, sc, lc, acc;
    rc = ha_jval && ha_jcom == 8'h80;
    sc = ha_jval && ha_jcom == 8'h90;
    lc = ha_jval && ha_jcom == 8'h45;
    m_r2 = m_r1;
    m_r1 = (m_ph == P_RST || i_reset) && !i_fatal_error;
    if (i_reset) begin
      m_ph = P_IDLE; m_prev = P_IDLE; m_hold = 0; m_out = 0; m_mask = 0; m_err = 0;
      m_llpend = 0; m_llv = 0; m_jcack = 0; m_llcmd = 0; m_llctxt = 0;
      m_s1 = 0; m_perr = 0; m_drop = 0; m_oerr = 0;
    end else begin
      old = m_ph;
      nph = old;
      if (rc) nph = P_RST;
      else if (old == P_IDLE && sc) nph = P_RUN;
      else if (old == P_RUN && (m_mask | i_app_done) == {CH{1'b1}}) nph = P_DRAIN;
      else if (old == P_DRAIN && m_out == 0 && !i_cmd_sent) nph = P_DONE;
      else if (old == P_DONE) nph = P_IDLE;
      else if (old == P_RST && m_hold == 1) nph = P_DONE;
      if (rc || old == P_DONE) begin
        m_mask = 0; m_err = 0;
      end else if (old == P_RUN) begin
        if (m_err == 0)
          for (int i = 0; i < CH; i++)
            if (i_app_done[i] && !m_mask[i] && i_app_error[i*AW +: AW] != 0) begin
              m_err = (64'd1 << 63) | (64'(i) << AW) | 64'(i_app_error[i*AW +: AW]);
              break;
            end
        m_mask = m_mask | i_app_done;
      end
      if (i_rsp_rcvd && !i_cmd_sent && m_out == 0 && old != P_RST) m_oerr = 1;
      if (rc || old == P_RST) m_out = 0;
      else if (i_cmd_sent && !i_rsp_rcvd && m_out < OMAX) m_out++;
      else if (i_rsp_rcvd && !i_cmd_sent && m_out > 0) m_out--;
      acc = lc && old != P_RST && !m_llpend;
      if (lc && old != P_RST && m_llpend) m_drop = 1;
      m_jcack = i_ll_ack && m_llpend;
      m_llv = acc;
      if (acc) begin
        d = int'(ha_jea & 64'h1FF);
        m_llcmd = ha_jea[63:48];
        m_llctxt = d * 2 + (($countones(d) % 2 == 0) ? 1 : 0);
      end
      if (rc) m_llpend = 0;
      else if (acc) m_llpend = 1;
      else if (i_ll_ack) m_llpend = 0;
      m_perr = m_s1;
      if (ha_jval && $countones({ha_jea, ha_jeapar}) % 2 == 0) m_s1 = 1;
      m_hold = rc ? RH : (m_hold > 0 ? m_hold - 1 : 0);
      m_prev = old;
      m_ph = nph;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("jrunning", ah_jrunning, (m_prev == P_RUN || m_prev == P_DRAIN) && (m_ph == P_RUN || m_ph == P_DRAIN));
      chk("cmd_en", o_cmd_en, m_prev == P_RUN);
      chk("jdone", ah_jdone, m_ph == P_DONE);
      chk("jerror", ah_jerror, m_ph == P_DONE ? m_err : 64'd0);
      chk("o_reset", o_reset, m_r2);
      chk("ll_v", o_ll_v, m_llv);
      chk("jcack", ah_jcack, m_jcack);
      chk("s1_perror", o_s1_perror, m_s1);
      chk("perror", o_perror, m_perr);
      chk("ll_drop", o_ll_drop, m_drop);
      chk("outst_err", o_outst_err, m_oerr);
      chk("tbreq_jyield", {ah_tbreq, ah_jyield}, 0);
      if (m_llv) begin
        chk("ll_cmd", o_ll_cmd, m_llcmd);
        chk("ll_ctxt", o_ll_ctxt, 64'(m_llctxt));
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic jcmd(input logic [7:0] op, input logic [63:0] ea);
    ha_jval = 1; ha_jcom = op; ha_jea = ea; ha_jeapar = ~^ea;
    tick();
    ha_jval = 0; ha_jcom = 0;
  endtask

  task automatic pulse_done(input logic [CH-1:0] d, input logic [CH*AW-1:0] e);
    i_app_done = d; i_app_error = e;
    tick();
    i_app_done = 0; i_app_error = 0;
  endtask

  task automatic wait_jdone(input int lim, input string nm);
    int n = 0;
    while (!ah_jdone && n < lim) begin
      tick();
      n++;
    end
    chk(nm, ah_jdone, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rcnt;
    bit seen;
    repeat (2) tick();
    chk_en = 1;
    tick();
    chk("lit_reset_held", o_reset, 1);
    chk("lit_reset_jrunning", ah_jrunning, 0);
    i_reset = 0;
    tick();
    chk("lit_reset_tail", o_reset, 1);
    tick();
    chk("lit_reset_low", o_reset, 0);

    jcmd(8'h90, 0);
    chk("lit_start_jrunning0", ah_jrunning, 0);
    chk("lit_start_cmd_en0", o_cmd_en, 0);
    tick();
    chk("lit_start_jrunning1", ah_jrunning, 1);
    chk("lit_start_cmd_en1", o_cmd_en, 1);
    i_cmd_sent = 1;
    repeat (3) tick();
    i_cmd_sent = 0;
    pulse_done(4'b0001, 0);
    pulse_done(4'b0010, 0);
    pulse_done(4'b0101, 32'h005A_0033);
    pulse_done(4'b1000, 0);
    for (int k = 0; k < 3; k++) begin
      i_rsp_rcvd = 1;
      tick();
      i_rsp_rcvd = 0;
      chk("lit_drain_wait", ah_jdone, 0);
    end
    wait_jdone(5, "lit_job1_done");
    chk("lit_job1_jerror", ah_jerror, 64'h8000_0000_0000_025A);
    chk("lit_job1_jrunning", ah_jrunning, 0);
    tick();

    jcmd(8'h90, 0);
    pulse_done(4'b1111, 32'h2200_1100);
    wait_jdone(5, "lit_job2_done");
    chk("lit_job2_jerror", ah_jerror, 64'h8000_0000_0000_0111);
    tick();
    jcmd(8'h90, 0);
    pulse_done(4'b1111, 0);
    wait_jdone(5, "lit_job3_done");
    chk("lit_job3_jerror", ah_jerror, 0);
    tick();

    ha_jval = 1; ha_jcom = 0; ha_jea = 64'h1234; ha_jeapar = ^ha_jea;
    tick();
    ha_jval = 0;
    chk("lit_s1_perror", o_s1_perror, 1);
    chk("lit_perror_lag", o_perror, 0);
    tick();
    chk("lit_perror", o_perror, 1);

    jcmd(8'h90, 0);
    i_cmd_sent = 1;
    repeat (2) tick();
    i_cmd_sent = 0;
    pulse_done(4'b1111, 32'h0000_0700);
    jcmd(8'h80, 0);
    rcnt = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (o_reset) rcnt++;
      if (ah_jdone) begin
        seen = 1;
        chk("lit_rst_jerror", ah_jerror, 0);
      end
      tick();
    end
    chk("lit_rst_width", rcnt, RH);
    chk("lit_rst_jdone", seen, 1);
    chk("lit_perror_sticky", {o_s1_perror, o_perror}, 2'b11);
    jcmd(8'h90, 0);
    pulse_done(4'b1111, 0);
    wait_jdone(3, "lit_post_rst_done");
    tick();

    i_fatal_error = 1;
    jcmd(8'h80, 0);
    rcnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (o_reset) rcnt++;
      tick();
    end
    i_fatal_error = 0;
    chk("lit_fatal_noreset", rcnt, 0);

    jcmd(8'h45, 64'hABCD_0000_0000_0155);
    chk("lit_ll_v", o_ll_v, 1);
    chk("lit_ll_cmd", o_ll_cmd, 16'hABCD);
    chk("lit_ll_ctxt", o_ll_ctxt, 10'h2AA);
    jcmd(8'h45, 64'h1111_0000_0000_0001);
    chk("lit_ll_v_drop", o_ll_v, 0);
    chk("lit_ll_drop", o_ll_drop, 1);
    i_ll_ack = 1;
    tick();
    i_ll_ack = 0;
    chk("lit_jcack", ah_jcack, 1);
    tick();
    chk("lit_jcack_end", ah_jcack, 0);

    i_rsp_rcvd = 1;
    tick();
    i_rsp_rcvd = 0;
    chk("lit_outst_err", o_outst_err, 1);
    jcmd(8'h90, 0);
    i_cmd_sent = 1;
    tick();
    i_rsp_rcvd = 1;
    tick();
    i_cmd_sent = 0; i_rsp_rcvd = 0;
    pulse_done(4'b1111, 0);
    repeat (5) tick();
    chk("lit_count_one_held", ah_jdone, 0);
    i_rsp_rcvd = 1;
    tick();
    i_rsp_rcvd = 0;
    wait_jdone(3, "lit_count_one_done");
    tick();

    jcmd(8'h90, 0);
    i_cmd_sent = 1;
    repeat (300) tick();
    i_cmd_sent = 0;
    pulse_done(4'b1111, 0);
    i_rsp_rcvd = 1;
    repeat (OMAX - 1) tick();
    i_rsp_rcvd = 0;
    repeat (3) tick();
    chk("lit_sat_held", ah_jdone, 0);
    i_rsp_rcvd = 1;
    tick();
    i_rsp_rcvd = 0;
    wait_jdone(3, "lit_sat_done");
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
